// File: rtl/fan_tach_monitor_pkg.sv
// Shared definitions for the fan tach monitor: FSM states, default counter width
// and the Beep polarity constants also used by the fan status LED stage.
package fan_tach_monitor_pkg;

    localparam int CNT_W_DEFAULT = 8;

    localparam logic BEEP_FAIL = 1'b1;
    localparam logic BEEP_OK   = 1'b0;

    typedef enum logic {
        ST_SPINUP  = 1'b0,
        ST_MONITOR = 1'b1
    } fan_mon_state_e;

endpackage

// File: rtl/fan_tach_edge.sv
// Per-fan tach front end: 2-FF synchronizer, optional glitch filter
// (FAN_TACH_GLITCH_FILTER_EN), and a single-cycle rising-edge pulse.
module fan_tach_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tach_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic level;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= tach_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef FAN_TACH_GLITCH_FILTER_EN
    logic       filt_q;
    logic       filt_d;
    logic [1:0] stable_q;
    logic [1:0] stable_d;

    // Level only flips once the new value has been seen on three consecutive cycles.
    always_comb begin
        filt_d   = filt_q;
        stable_d = 2'd0;
        if (sync2_q != filt_q) begin
            if (stable_q == 2'd2) begin
                filt_d = sync2_q;
            end else begin
                stable_d = stable_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q   <= 1'b0;
            stable_q <= 2'd0;
        end else begin
            filt_q   <= filt_d;
            stable_q <= stable_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise_o = level & ~prev_q;

endmodule

// File: rtl/fan_tach_monitor.sv
// Fan tachometer monitor: per-window pulse counts, consecutive-low-window fail
// detection with spin-up blanking, sticky flags and Beep. Optional glitch filter
// in the tach front end is enabled by FAN_TACH_GLITCH_FILTER_EN.
module fan_tach_monitor
    import fan_tach_monitor_pkg::*;
#(
    parameter int NUM_FANS       = 4,
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int WIN_STROBES    = 64,
    parameter int FAIL_WINDOWS   = 2,
    parameter int SPINUP_WINDOWS = 2
) (
    input  logic                      SlowClock,
    input  logic                      Reset_N,
    input  logic                      Strobe16ms,
    input  logic [NUM_FANS-1:0]       FanTach,
    input  logic [NUM_FANS-1:0]       FanEnable,
    input  logic [CNT_W-1:0]          MinPulseCnt,
    input  logic                      FanAlarmClr,
    output logic [NUM_FANS*CNT_W-1:0] FanTachCnt,
    output logic [NUM_FANS-1:0]       FanFail,
    output logic [NUM_FANS-1:0]       FanFailSticky,
    output logic                      Beep
);

    localparam int               WIN_W     = (WIN_STROBES > 1) ? $clog2(WIN_STROBES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_STROBES - 1);
    localparam logic [2:0]       FAIL_MAX  = 3'(FAIL_WINDOWS);
    localparam logic [2:0]       SPIN_LAST = 3'(SPINUP_WINDOWS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [NUM_FANS-1:0]       rise;
    logic [NUM_FANS-1:0]       low;
    logic                      win_end;
    logic [WIN_W-1:0]          win_cnt_q, win_cnt_d;
    fan_mon_state_e            state_q, state_d;
    logic [2:0]                spin_cnt_q, spin_cnt_d;
    logic [CNT_W-1:0]          edge_cnt_q [NUM_FANS];
    logic [CNT_W-1:0]          edge_cnt_d [NUM_FANS];
    logic [2:0]                fail_cnt_q [NUM_FANS];
    logic [2:0]                fail_cnt_d [NUM_FANS];
    logic [NUM_FANS*CNT_W-1:0] tach_cnt_q, tach_cnt_d;
    logic [NUM_FANS-1:0]       fail_q, fail_d;
    logic [NUM_FANS-1:0]       sticky_q, sticky_d;
    logic                      beep_q, beep_d;

    for (genvar g = 0; g < NUM_FANS; g++) begin : g_fan
        fan_tach_edge u_edge (
            .clk_i  (SlowClock),
            .rst_ni (Reset_N),
            .tach_i (FanTach[g]),
            .rise_o (rise[g])
        );
    end

    assign win_end = Strobe16ms & (win_cnt_q == WIN_LAST);

    always_comb begin
        win_cnt_d = win_cnt_q;
        if (win_end) begin
            win_cnt_d = '0;
        end else if (Strobe16ms) begin
            win_cnt_d = win_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        spin_cnt_d = spin_cnt_q;
        unique case (state_q)
            ST_SPINUP: begin
                if (win_end) begin
                    if (spin_cnt_q == SPIN_LAST) begin
                        state_d    = ST_MONITOR;
                        spin_cnt_d = '0;
                    end else begin
                        spin_cnt_d = spin_cnt_q + 1'b1;
                    end
                end
            end
            ST_MONITOR: begin
                state_d = ST_MONITOR;
            end
        endcase
    end

    // An edge landing in the WinEnd cycle is the first edge of the new window.
    always_comb begin
        tach_cnt_d = tach_cnt_q;
        low        = '0;
        fail_d     = '0;
        for (int i = 0; i < NUM_FANS; i++) begin
            low[i]        = FanEnable[i] & (edge_cnt_q[i] < MinPulseCnt);
            edge_cnt_d[i] = edge_cnt_q[i];
            fail_cnt_d[i] = fail_cnt_q[i];

            if (win_end) begin
                tach_cnt_d[i*CNT_W +: CNT_W] = edge_cnt_q[i];
                edge_cnt_d[i] = rise[i] ? CNT_W'(1) : '0;
            end else if (rise[i] && (edge_cnt_q[i] != CNT_MAX)) begin
                edge_cnt_d[i] = edge_cnt_q[i] + 1'b1;
            end

            if (!FanEnable[i] || (state_q == ST_SPINUP)) begin
                fail_cnt_d[i] = '0;
            end else if (win_end) begin
                if (!low[i]) begin
                    fail_cnt_d[i] = '0;
                end else if (fail_cnt_q[i] != FAIL_MAX) begin
                    fail_cnt_d[i] = fail_cnt_q[i] + 1'b1;
                end
            end

            fail_d[i] = (fail_cnt_d[i] == FAIL_MAX);
        end
    end

    assign sticky_d = (sticky_q & ~{NUM_FANS{FanAlarmClr}}) | fail_q;
    assign beep_d   = (|fail_q) ? BEEP_FAIL : BEEP_OK;

    always_ff @(posedge SlowClock or negedge Reset_N) begin
        if (!Reset_N) begin
            win_cnt_q  <= '0;
            state_q    <= ST_SPINUP;
            spin_cnt_q <= '0;
            tach_cnt_q <= '0;
            fail_q     <= '0;
            sticky_q   <= '0;
            beep_q     <= BEEP_OK;
            for (int i = 0; i < NUM_FANS; i++) begin
                edge_cnt_q[i] <= '0;
                fail_cnt_q[i] <= '0;
            end
        end else begin
            win_cnt_q  <= win_cnt_d;
            state_q    <= state_d;
            spin_cnt_q <= spin_cnt_d;
            tach_cnt_q <= tach_cnt_d;
            fail_q     <= fail_d;
            sticky_q   <= sticky_d;
            beep_q     <= beep_d;
            for (int i = 0; i < NUM_FANS; i++) begin
                edge_cnt_q[i] <= edge_cnt_d[i];
                fail_cnt_q[i] <= fail_cnt_d[i];
            end
        end
    end

    assign FanTachCnt    = tach_cnt_q;
    assign FanFail       = fail_q;
    assign FanFailSticky = sticky_q;
    assign Beep          = beep_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Directed plus randomized bench for fan_tach_monitor, checked against a
// window-level behavioural model of counts, fail streaks and sticky flags.
module tb_fan_tach_monitor;

    localparam int NF   = 4;
    localparam int CW   = 8;
    localparam int WS   = 4;
    localparam int FW   = 2;
    localparam int SW   = 2;
    localparam int CMAX = 255;
`ifdef FAN_TACH_GLITCH_FILTER_EN
    localparam int RISE_LAT = 5;
    localparam bit FILT     = 1'b1;
`else
    localparam int RISE_LAT = 2;
    localparam bit FILT     = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               Reset_N;
    logic               Strobe16ms;
    logic [NF-1:0]      FanTach;
    logic [NF-1:0]      FanEnable;
    logic [CW-1:0]      MinPulseCnt;
    logic               FanAlarmClr;
    logic [NF*CW-1:0]   FanTachCnt;
    logic [NF-1:0]      FanFail;
    logic [NF-1:0]      FanFailSticky;
    logic               Beep;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            m_cnt    [NF];
    int            m_carry  [NF];
    int            m_consec [NF];
    int            m_tach   [NF];
    int            m_win;
    logic [NF-1:0] m_fail;
    logic [NF-1:0] m_sticky;

    always #5 clk = ~clk;

    fan_tach_monitor #(
        .NUM_FANS       (NF),
        .CNT_W          (CW),
        .WIN_STROBES    (WS),
        .FAIL_WINDOWS   (FW),
        .SPINUP_WINDOWS (SW)
    ) dut (
        .SlowClock     (clk),
        .Reset_N       (Reset_N),
        .Strobe16ms    (Strobe16ms),
        .FanTach       (FanTach),
        .FanEnable     (FanEnable),
        .MinPulseCnt   (MinPulseCnt),
        .FanAlarmClr   (FanAlarmClr),
        .FanTachCnt    (FanTachCnt),
        .FanFail       (FanFail),
        .FanFailSticky (FanFailSticky),
        .Beep          (Beep)
    );

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int f = 0; f < NF; f++) begin
            m_cnt[f] = 0; m_carry[f] = 0; m_consec[f] = 0; m_tach[f] = 0;
        end
        m_win = 0; m_fail = '0; m_sticky = '0;
    endtask

    task automatic pulses(input int a, input int b, input int c, input int d);
        int n [NF];
        int mx;
        n  = '{a, b, c, d};
        mx = 0;
        for (int f = 0; f < NF; f++) begin
            if (n[f] > mx) mx = n[f];
            m_cnt[f] = sat(m_cnt[f] + n[f]);
        end
        for (int k = 0; k < mx; k++) begin
            for (int f = 0; f < NF; f++) FanTach[f] = (k < n[f]);
            repeat (4) tick();
            FanTach = '0;
            repeat (4) tick();
        end
    endtask

    task automatic glitch(input int f, input int w);
        FanTach[f] = 1'b1;
        repeat (w) tick();
        FanTach[f] = 1'b0;
        repeat (8) tick();
        if (!FILT) m_cnt[f] = sat(m_cnt[f] + 1);
    endtask

    task automatic close_window(input bit coin, input bit clr);
        bit low;
        repeat (8) tick();
        for (int s = 0; s < WS - 1; s++) begin
            Strobe16ms = 1'b1; tick();
            Strobe16ms = 1'b0; tick();
        end
        if (coin) begin
            FanTach[0] = 1'b1;
            repeat (RISE_LAT) tick();
            m_carry[0] = 1;
        end
        Strobe16ms = 1'b1; tick();
        Strobe16ms = 1'b0;
        FanTach[0] = 1'b0;

        m_win++;
        for (int f = 0; f < NF; f++) begin
            m_tach[f] = m_cnt[f];
            low = FanEnable[f] && (m_cnt[f] < int'(MinPulseCnt));
            if (m_win <= SW || !FanEnable[f]) m_consec[f] = 0;
            else if (low) m_consec[f] = (m_consec[f] + 1 > FW) ? FW : m_consec[f] + 1;
            else m_consec[f] = 0;
            m_fail[f]  = (m_consec[f] == FW);
            m_cnt[f]   = m_carry[f];
            m_carry[f] = 0;
        end

        for (int f = 0; f < NF; f++)
            check($sformatf("w%0d_tachcnt%0d", m_win, f), 32'(FanTachCnt[f*CW +: CW]), m_tach[f]);
        check($sformatf("w%0d_fanfail", m_win), 32'(FanFail), 32'(m_fail));
        if (clr) FanAlarmClr = 1'b1;
        tick();
        FanAlarmClr = 1'b0;
        m_sticky = (m_sticky & ~{NF{clr}}) | m_fail;
        check($sformatf("w%0d_beep", m_win), 32'(Beep), 32'(|m_fail));
        check($sformatf("w%0d_sticky", m_win), 32'(FanFailSticky), 32'(m_sticky));
        repeat (8) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tachcnt"}, 32'(FanTachCnt != '0), 32'(0));
        check({tag, "_fanfail"}, 32'(FanFail), 32'(0));
        check({tag, "_sticky"}, 32'(FanFailSticky), 32'(0));
        check({tag, "_beep"}, 32'(Beep), 32'(0));
    endtask

    initial begin
        Reset_N     = 1'b0;
        Strobe16ms  = 1'b0;
        FanTach     = '0;
        FanEnable   = 4'hF;
        MinPulseCnt = 8'd10;
        FanAlarmClr = 1'b0;
        model_reset();
        repeat (3) tick();
        check_all_zero("reset");
        Reset_N = 1'b1;
        tick();

        // Spin-up with dead fans, then healthy fans.
        close_window(1'b0, 1'b0);
        close_window(1'b0, 1'b0);
        repeat (2) begin pulses(20, 20, 20, 20); close_window(1'b0, 1'b0); end

        // Fan2 stops, then resumes while fan1 stops; clear lands with fan1 failing.
        repeat (2) begin pulses(20, 20, 0, 20); close_window(1'b0, 1'b0); end
        pulses(20, 0, 20, 20); close_window(1'b0, 1'b0);
        pulses(20, 0, 20, 20); close_window(1'b0, 1'b1);
        pulses(20, 20, 20, 20); close_window(1'b0, 1'b0);
        FanAlarmClr = 1'b1; tick(); FanAlarmClr = 1'b0;
        m_sticky = m_fail;
        check("clr_sticky", 32'(FanFailSticky), 32'(m_sticky));

        // Saturation and a disabled dead fan.
        FanEnable = 4'h7;
        m_consec[3] = 0;
        pulses(300, 20, 20, 0); close_window(1'b0, 1'b0);
        pulses(20, 20, 20, 0);  close_window(1'b0, 1'b0);
        pulses(20, 20, 20, 0);  close_window(1'b0, 1'b0);
        FanEnable = 4'hF;

        // Short glitches on fan1 and an edge coinciding with WinEnd on fan0.
        pulses(20, 20, 20, 20);
        repeat (3) glitch(1, 1);
        repeat (3) glitch(1, 2);
        close_window(1'b1, 1'b0);
        pulses(20, 20, 20, 20); close_window(1'b0, 1'b0);

        // Failure, then a reset pulse mid-window restarts spin-up.
        repeat (2) begin pulses(20, 20, 0, 20); close_window(1'b0, 1'b0); end
        pulses(5, 5, 5, 5);
        Reset_N = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) tick();
        Reset_N = 1'b1;
        model_reset();
        tick();
        repeat (4) begin pulses(20, 20, 0, 20); close_window(1'b0, 1'b0); end

        // Randomized windows, including MinPulseCnt of zero.
        repeat (6) begin
            MinPulseCnt = 8'($urandom_range(0, 16));
            pulses($urandom_range(0, 24), $urandom_range(0, 24),
                   $urandom_range(0, 24), $urandom_range(0, 24));
            close_window(1'b0, 1'($urandom_range(0, 1)));
        end
        MinPulseCnt = 8'd0;
        repeat (3) close_window(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
